gcd_entry_ctrl: RTL

Sequencing controller for the lab GCD datapath. It turns the board's slow human inputs (one push-button, a 4-bit switch bank) into two signed 8-bit operands, entered high nibble first. It then starts the GCD datapath on their magnitudes, waits for completion with a timeout, and drives the 8 LEDs with either the entry in progress or the final result. It sits between the board I/O and the GCD datapath, which becomes a pure start/done compute engine.

---
 rtl/gcd_entry_ctrl_if.sv | 11 +
 rtl/gcd_entry_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/gcd_entry_ctrl_if.sv
// Start/done handshake between the entry controller and the GCD datapath.
interface gcd_entry_ctrl_if;
    logic       dp_start;
    logic [7:0] dp_a;
    logic [7:0] dp_b;
    logic       dp_done;
    logic [7:0] dp_result;

    modport master (output dp_start, dp_a, dp_b, input dp_done, dp_result);
    modport slave  (input dp_start, dp_a, dp_b, output dp_done, dp_result);
endinterface

// File: rtl/gcd_entry_ctrl.sv
// Board-side sequencer: debounced nibble entry of two signed operands, GCD run
// with timeout, and LED display of the entry in progress or the final result.
module gcd_entry_ctrl #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned WAIT_MAX = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_enter,
    input  logic [3:0]              sw,
    gcd_entry_ctrl_if.master        dp,
    output logic [7:0]              led,
    output logic                    busy
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE + 1);
    localparam int unsigned WT_W = $clog2(WAIT_MAX);

    typedef enum logic [2:0] {A_HI, A_LO, B_HI, B_LO, START, WAIT, SHOW} state_e;

    state_e            state_q, state_d;
    logic              sync1_q, sync1_d, sync2_q, sync2_d;
    logic              db_q, db_d, press_q, press_d;
    logic [DB_W-1:0]   dbcnt_q, dbcnt_d;
    logic [WT_W-1:0]   wcnt_q, wcnt_d;
    logic [7:0]        entry_q, entry_d;
    logic [7:0]        a_q, a_d, b_q, b_d;
    logic [7:0]        result_q, result_d;
    logic [7:0]        led_q, led_d;
    logic              busy_q, busy_d, dp_start_q, dp_start_d;

    // Two's complement magnitude; 0x80 maps to itself, which is 128 unsigned.
    function automatic logic [7:0] mag8(input logic [7:0] x);
        return x[7] ? (~x + 8'd1) : x;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= A_HI;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_q       <= 1'b0;
            press_q    <= 1'b0;
            dbcnt_q    <= '0;
            wcnt_q     <= '0;
            entry_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            led_q      <= '0;
            busy_q     <= 1'b0;
            dp_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_q       <= db_d;
            press_q    <= press_d;
            dbcnt_q    <= dbcnt_d;
            wcnt_q     <= wcnt_d;
            entry_q    <= entry_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
            led_q      <= led_d;
            busy_q     <= busy_d;
            dp_start_q <= dp_start_d;
        end
    end

    always_comb begin
        sync1_d    = key_enter;
        sync2_d    = sync1_q;
        db_d       = db_q;
        dbcnt_d    = '0;
        state_d    = state_q;
        entry_d    = entry_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        wcnt_d     = wcnt_q;

        // Level flips only after DEBOUNCE consecutive disagreeing samples.
        if (sync2_q != db_q) begin
            if (dbcnt_q == DB_W'(DEBOUNCE - 1)) begin
                db_d = sync2_q;
            end else begin
                dbcnt_d = dbcnt_q + DB_W'(1);
            end
        end
        press_d = db_d & ~db_q;

        case (state_q)
            A_HI, B_HI, SHOW: begin
                if (press_q) begin
                    entry_d = {sw, 4'h0};
                    state_d = (state_q == B_HI) ? B_LO : A_LO;
                end
            end
            A_LO: begin
                if (press_q) begin
                    a_d     = mag8({entry_q[7:4], sw});
                    entry_d = '0;
                    state_d = B_HI;
                end
            end
            B_LO: begin
                if (press_q) begin
                    b_d     = mag8({entry_q[7:4], sw});
                    entry_d = '0;
                    state_d = START;
                end
            end
            START: begin
                wcnt_d = '0;
                if ((a_q != 8'h00) && (b_q != 8'h00)) begin
                    state_d = WAIT;
                end else begin
                    result_d = (a_q == 8'h00) ? b_q : a_q;
                    state_d  = SHOW;
                end
            end
            WAIT: begin
                wcnt_d = wcnt_q + WT_W'(1);
                if (dp.dp_done) begin
                    result_d = dp.dp_result;
                    state_d  = SHOW;
                end else if (wcnt_d == WT_W'(WAIT_MAX - 1)) begin
                    result_d = 8'hFF;
                    state_d  = SHOW;
                end
            end
            default: state_d = A_HI;
        endcase

        // Outputs are registered, so they are derived from the next-state values.
        busy_d     = (state_d == START) || (state_d == WAIT);
        dp_start_d = (state_d == START) && (a_d != 8'h00) && (b_d != 8'h00);
        case (state_d)
            START, WAIT: led_d = 8'h00;
            SHOW:        led_d = result_d;
            default:     led_d = entry_d;
        endcase
    end

    assign dp.dp_start = dp_start_q;
    assign dp.dp_a     = a_q;
    assign dp.dp_b     = b_q;
    assign led         = led_q;
    assign busy        = busy_q;

endmodule
